// File: rtl/uart_if_pkg.sv
// Constants and state encoding shared by the UART word serializer and the
// receive-side word assembler, so both ends agree on byte order and width.
package uart_if_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } tx_state_t;

endpackage

// File: rtl/interfaz_tx_word.sv
// Word-to-byte serializer for the debug UART link: sends one word MSB byte first,
// waiting for the byte transmitter's done before issuing the next byte.
//
// state  | meaning
// IDLE   | waiting for send; latches din and clears the byte counter on accept
// SEND   | one-cycle start pulse to the UART with the current top byte
// WAIT   | byte on the wire; tx_done shifts to the next byte or ends the word
// FINISH | one-cycle done pulse, then back to IDLE
module interfaz_tx_word
  import uart_if_pkg::*;
#(
  parameter int N_BYTES = WORD_BYTES
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_send,
  input  logic [8*N_BYTES-1:0] i_din,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_uart_tx_start,
  output logic [BYTE_W-1:0]    o_uart_dout,
  input  logic                 i_uart_tx_done
);

  localparam int DATA_W = BYTE_W * N_BYTES;
  localparam int CNT_W  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(N_BYTES - 1);

  tx_state_t          r_state;
  tx_state_t          w_state_nxt;
  logic [DATA_W-1:0]  r_shreg;
  logic [DATA_W-1:0]  w_shreg_nxt;
  logic [CNT_W-1:0]   r_byte_cnt;
  logic [CNT_W-1:0]   w_byte_cnt_nxt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_byte_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_shreg    <= w_shreg_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
    end
  end

  // tx_done is only honoured in WAIT so a stale pulse cannot skip a byte
  always_comb begin
    w_state_nxt    = r_state;
    w_shreg_nxt    = r_shreg;
    w_byte_cnt_nxt = r_byte_cnt;
    case (r_state)
      IDLE: begin
        if (i_send) begin
          w_shreg_nxt    = i_din;
          w_byte_cnt_nxt = '0;
          w_state_nxt    = SEND;
        end
      end
      SEND: begin
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (i_uart_tx_done) begin
          w_shreg_nxt = r_shreg << BYTE_W;
          if (r_byte_cnt == LAST_BYTE) begin
            w_state_nxt = FINISH;
          end else begin
            w_byte_cnt_nxt = r_byte_cnt + 1'b1;
            w_state_nxt    = SEND;
          end
        end
      end
      FINISH: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // The shift register is empty again once a word completes, so dout reads 0 in IDLE
  assign o_busy          = (r_state != IDLE);
  assign o_done          = (r_state == FINISH);
  assign o_uart_tx_start = (r_state == SEND);
  assign o_uart_dout     = r_shreg[DATA_W-1 -: BYTE_W];

endmodule

// File: tb/tb_interfaz_tx_word.sv
// Directed bench for interfaz_tx_word with a UART responder (tx_done 3 cycles
// after each start) and a receive-side word assembler model for loopback.
module tb_interfaz_tx_word;
  import uart_if_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        send;
  logic [31:0] din;
  logic        busy;
  logic        done;
  logic        start;
  logic [7:0]  dout;
  logic        model_done = 1'b0;
  logic        spur_done  = 1'b0;
  logic        tx_done;

  assign tx_done = model_done | spur_done;

  always #5 clk = ~clk;

  interfaz_tx_word dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_send          (send),
    .i_din           (din),
    .o_busy          (busy),
    .o_done          (done),
    .o_uart_tx_start (start),
    .o_uart_dout     (dout),
    .i_uart_tx_done  (tx_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  tx_q[$];
  logic [31:0] rx_q[$];
  int          start_cnt = 0;
  int          done_cnt  = 0;
  int          go_cnt    = 0;
  int          multi_cnt = 0;
  logic        prev_start = 1'b0;
  logic [31:0] asm_word = '0;
  int          asm_n = 0;
  int          cd = 0;

  // UART responder, byte log and receive-side assembler, all at the negedge
  always @(negedge clk) begin
    model_done = 1'b0;
    if (cd != 0) begin
      cd = cd - 1;
      if (cd == 0) model_done = 1'b1;
    end
    if (start === 1'b1) cd = 3;
    if (start === 1'b1 && prev_start === 1'b1) multi_cnt++;
    prev_start = start;
    if (done === 1'b1) done_cnt++;
    if (reset === 1'b1) begin
      asm_word = '0;
      asm_n    = 0;
    end else if (start === 1'b1) begin
      tx_q.push_back(dout);
      start_cnt++;
      asm_word = {asm_word[23:0], dout};
      asm_n++;
      if (asm_n == 4) begin
        rx_q.push_back(asm_word);
        go_cnt++;
        asm_n = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_done_timeout"}, 32'(n < 200), 32'd1);
  endtask

  task automatic check_bytes(input string tag, input logic [31:0] exp);
    logic [7:0] b;
    chk({tag, "_nbytes"}, tx_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      b = (tx_q.size() > i) ? tx_q[i] : 8'hxx;
      chk($sformatf("%s_byte%0d", tag, i), b, exp[31-8*i -: 8]);
    end
  endtask

  initial begin
    int d0;
    int s0;
    int g0;
    int k;
    int n;
    logic [31:0] w;

    // reset held with send asserted
    reset = 1'b1;
    send  = 1'b1;
    din   = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_outputs", {busy, done, start, dout}, 32'd0);
    end
    reset = 1'b0;
    send  = 1'b0;
    repeat (6) step();
    chk("post_reset_no_start", start_cnt, 32'd0);
    chk("post_reset_busy", busy, 32'd0);

    // basic word
    tx_q.delete();
    d0 = done_cnt;
    din  = 32'hDEADBEEF;
    send = 1'b1;
    step();
    chk("first_start_latency", start, 32'd1);
    chk("first_byte_on_start", dout, 32'hDE);
    send = 1'b0;
    din  = 32'h0BADF00D;
    step();
    chk("busy_in_wait", busy, 32'd1);
    chk("start_single_cycle", start, 32'd0);
    chk("dout_held_in_wait", dout, 32'hDE);
    wait_done("basic");
    send = 1'b1;
    din  = 32'h55555555;
    step();
    send = 1'b0;
    chk("busy_after_done", busy, 32'd0);
    chk("send_in_finish_ignored", start, 32'd0);
    step();
    chk("send_in_finish_no_busy", busy, 32'd0);
    check_bytes("basic", 32'hDEADBEEF);
    chk("basic_done_count", done_cnt - d0, 32'd1);

    // send while busy is dropped
    tx_q.delete();
    d0 = done_cnt;
    din  = 32'hDEADBEEF;
    send = 1'b1;
    step();
    send = 1'b0;
    repeat (5) step();
    din  = 32'h12345678;
    send = 1'b1;
    step();
    send = 1'b0;
    wait_done("lockout");
    step();
    s0 = start_cnt;
    repeat (20) step();
    chk("lockout_no_queued_start", start_cnt - s0, 32'd0);
    check_bytes("lockout", 32'hDEADBEEF);
    chk("lockout_done_count", done_cnt - d0, 32'd1);

    // spurious tx_done in IDLE and in SEND
    spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    chk("idle_spur_no_start", start, 32'd0);
    chk("idle_spur_no_busy", busy, 32'd0);
    tx_q.delete();
    d0 = done_cnt;
    din  = 32'hA1B2C3D4;
    send = 1'b1;
    step();
    send = 1'b0;
    spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    chk("send_spur_dout_held", dout, 32'hA1);
    chk("send_spur_no_restart", start, 32'd0);
    wait_done("spurious");
    step();
    check_bytes("spurious", 32'hA1B2C3D4);
    chk("spurious_done_count", done_cnt - d0, 32'd1);
    chk("no_multi_cycle_start", multi_cnt, 32'd0);

    // reset after the second tx_done aborts the word
    d0 = done_cnt;
    din  = 32'hDEADBEEF;
    send = 1'b1;
    step();
    send = 1'b0;
    k = 0;
    n = 0;
    while (k < 2 && n < 100) begin
      step();
      n++;
      if (tx_done === 1'b1) k++;
    end
    chk("abort_reached_second_done", k, 32'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_outputs", {busy, done, start, dout}, 32'd0);
    s0 = start_cnt;
    repeat (10) step();
    chk("abort_no_start", start_cnt - s0, 32'd0);
    chk("abort_no_done", done_cnt - d0, 32'd0);
    tx_q.delete();
    rx_q.delete();
    d0 = done_cnt;
    din  = 32'h01020304;
    send = 1'b1;
    step();
    send = 1'b0;
    wait_done("after_abort");
    step();
    check_bytes("after_abort", 32'h01020304);
    chk("after_abort_done_count", done_cnt - d0, 32'd1);
    w = (rx_q.size() > 0) ? rx_q[0] : 32'hxxxxxxxx;
    chk("after_abort_rebuilt", w, 32'h01020304);

    // back-to-back loopback
    rx_q.delete();
    g0 = go_cnt;
    din  = 32'hCAFEF00D;
    send = 1'b1;
    step();
    send = 1'b0;
    wait_done("loop_w0");
    step();
    din  = 32'h00000000;
    send = 1'b1;
    step();
    send = 1'b0;
    chk("b2b_start", start, 32'd1);
    chk("b2b_first_byte", dout, 32'h00);
    wait_done("loop_w1");
    step();
    chk("loop_go_count", go_cnt - g0, 32'd2);
    chk("loop_word_count", rx_q.size(), 32'd2);
    w = (rx_q.size() > 0) ? rx_q[0] : 32'hxxxxxxxx;
    chk("loop_word0", w, 32'hCAFEF00D);
    w = (rx_q.size() > 1) ? rx_q[1] : 32'hxxxxxxxx;
    chk("loop_word1", w, 32'h00000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
